// File: rtl/siphash_pkg.sv
// Shared definitions for the SipHash message front end: FSM state encoding,
// datapath widths and the little-endian byte-insert helper.
package siphash_pkg;

    localparam int SIPHASH_WORD_W = 64;
    localparam int SIPHASH_BYTE_W = 8;
    localparam int SIPHASH_LEN_W  = 8;
    localparam int SIPHASH_CNT_W  = $clog2(SIPHASH_WORD_W / SIPHASH_BYTE_W);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_ACCEPT = 3'd2,
        ST_COMP   = 3'd3,
        ST_CWAIT  = 3'd4,
        ST_FIN    = 3'd5,
        ST_FWAIT  = 3'd6
    } siphash_state_t;

    // Place one byte at lane idx of a word; lane 0 is the least significant byte.
    function automatic logic [SIPHASH_WORD_W-1:0] siphash_insert_byte(
        input logic [SIPHASH_WORD_W-1:0] word,
        input logic [SIPHASH_CNT_W-1:0]  idx,
        input logic [SIPHASH_BYTE_W-1:0] b
    );
        logic [SIPHASH_WORD_W-1:0] w;
        w = word;
        w[{idx, 3'b000} +: SIPHASH_BYTE_W] = b;
        return w;
    endfunction

endpackage

// File: rtl/siphash_msg_feeder.sv
// Byte-stream front end for siphash_core. Packs bytes little-endian into
// 64-bit words, appends the SipHash length byte in the final block and
// sequences the core's initalize / compress / finalize commands.
//
// Build option: SIPHASH_FEEDER_LONG_EN adds the long_mode input, latched at
// start and driven on core_long for the whole message; otherwise core_long=0.
//
// state   | meaning
// IDLE    | waiting for start
// INIT    | core_initalize pulse
// ACCEPT  | taking bytes into the current word
// COMP    | core_compress pulse, core_mi = word
// CWAIT   | guard cycle, then wait for core ready and pick next block
// FIN     | core_finalize pulse
// FWAIT   | guard cycle, then wait for core ready and pulse done
module siphash_msg_feeder
    import siphash_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      msg_empty,
    input  logic                      in_valid,
    input  logic [SIPHASH_BYTE_W-1:0] in_data,
    input  logic                      in_last,
`ifdef SIPHASH_FEEDER_LONG_EN
    input  logic                      long_mode,
`endif
    output logic                      in_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      core_initalize,
    output logic                      core_compress,
    output logic                      core_finalize,
    output logic [SIPHASH_WORD_W-1:0] core_mi,
    output logic                      core_long,
    input  logic                      core_ready
);

    siphash_state_t              r_state;
    logic [SIPHASH_WORD_W-1:0]   r_word;
    logic [SIPHASH_CNT_W-1:0]    r_byte_cnt;
    logic [SIPHASH_LEN_W-1:0]    r_len;
    logic                        r_pad_pend;
    logic                        r_last_blk;
    logic                        r_guard;
    logic                        r_empty;
    logic                        r_in_ready;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_init;
    logic                        r_comp;
    logic                        r_fin;
`ifdef SIPHASH_FEEDER_LONG_EN
    logic                        r_long;
`endif

    logic [SIPHASH_WORD_W-1:0]   w_word_ins;
    logic [SIPHASH_WORD_W-1:0]   w_word_last;
    logic [SIPHASH_LEN_W-1:0]    w_len_inc;
    logic                        w_accept;
    logic                        w_cnt_full;

    // Byte insert and short-final-block padding computed ahead of the accept edge.
    always_comb begin
        w_word_ins  = siphash_insert_byte(r_word, r_byte_cnt, in_data);
        w_len_inc   = r_len + 8'd1;
        w_word_last = {w_len_inc, w_word_ins[SIPHASH_WORD_W-SIPHASH_LEN_W-1:0]};
        w_accept    = in_valid & r_in_ready;
        w_cnt_full  = (r_byte_cnt == 3'd7);
    end

    // Sequencing FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_len      <= '0;
            r_pad_pend <= 1'b0;
            r_last_blk <= 1'b0;
            r_guard    <= 1'b0;
            r_empty    <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_init     <= 1'b0;
            r_comp     <= 1'b0;
            r_fin      <= 1'b0;
`ifdef SIPHASH_FEEDER_LONG_EN
            r_long     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_init <= 1'b0;
            r_comp <= 1'b0;
            r_fin  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_word     <= '0;
                        r_byte_cnt <= '0;
                        r_len      <= '0;
                        r_pad_pend <= 1'b0;
                        r_last_blk <= 1'b0;
                        r_guard    <= 1'b0;
                        r_empty    <= msg_empty;
`ifdef SIPHASH_FEEDER_LONG_EN
                        r_long     <= long_mode;
`endif
                        r_init     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (r_empty) begin
                        // Empty message: a single block holding only length 0.
                        r_word     <= '0;
                        r_last_blk <= 1'b1;
                        r_comp     <= 1'b1;
                        r_state    <= ST_COMP;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        r_len      <= w_len_inc;
                        if (in_last && !w_cnt_full) begin
                            // Room left in this word: length byte goes in lane 7.
                            r_word     <= w_word_last;
                            r_last_blk <= 1'b1;
                        end else begin
                            r_word <= w_word_ins;
                            // Exact multiple of 8: length needs a block of its own.
                            if (in_last) r_pad_pend <= 1'b1;
                        end
                        if (in_last || w_cnt_full) begin
                            r_in_ready <= 1'b0;
                            r_comp     <= 1'b1;
                            r_state    <= ST_COMP;
                        end
                    end
                end
                ST_COMP: begin
                    r_guard <= 1'b1;
                    r_state <= ST_CWAIT;
                end
                ST_CWAIT: begin
                    // Core ready only drops a cycle after the command, so skip one cycle.
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (core_ready) begin
                        if (r_pad_pend) begin
                            r_word     <= {r_len, {(SIPHASH_WORD_W-SIPHASH_LEN_W){1'b0}}};
                            r_pad_pend <= 1'b0;
                            r_last_blk <= 1'b1;
                            r_comp     <= 1'b1;
                            r_state    <= ST_COMP;
                        end else if (r_last_blk) begin
                            r_fin   <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_word     <= '0;
                            r_in_ready <= 1'b1;
                            r_state    <= ST_ACCEPT;
                        end
                    end
                end
                ST_FIN: begin
                    r_guard <= 1'b1;
                    r_state <= ST_FWAIT;
                end
                ST_FWAIT: begin
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (core_ready) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign core_initalize = r_init;
    assign core_compress  = r_comp;
    assign core_finalize  = r_fin;
    assign core_mi        = r_word;
`ifdef SIPHASH_FEEDER_LONG_EN
    assign core_long      = r_long;
`else
    assign core_long      = 1'b0;
`endif

endmodule

// File: tb/tb_siphash_msg_feeder.sv
// Testbench for siphash_msg_feeder: a table of message cases plus random ones,
// a behavioural siphash_core ready model, and a byte-level model of the
// expected compress words (full 8-byte LE words, then a final block holding
// the tail bytes with len mod 256 in the top byte).
module tb_siphash_msg_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, msg_empty, in_valid, in_last;
    logic [7:0]  in_data;
    logic        in_ready, busy, done;
    logic        core_initalize, core_compress, core_finalize, core_long, core_ready;
    logic [63:0] core_mi;
`ifdef SIPHASH_FEEDER_LONG_EN
    logic        long_mode = 1'b0;
`endif

    always #5 clk = ~clk;

    siphash_msg_feeder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .msg_empty(msg_empty),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
`ifdef SIPHASH_FEEDER_LONG_EN
        .long_mode(long_mode),
`endif
        .in_ready(in_ready), .busy(busy), .done(done),
        .core_initalize(core_initalize), .core_compress(core_compress),
        .core_finalize(core_finalize), .core_mi(core_mi),
        .core_long(core_long), .core_ready(core_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Core model: ready drops one cycle after any command, stays low 1..5 cycles.
    bit m_pend;
    int m_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready <= 1'b1;
            m_pend     <= 1'b0;
            m_cnt      <= 0;
        end else begin
            if (m_pend) begin
                core_ready <= 1'b0;
                m_cnt      <= $urandom_range(1, 5);
                m_pend     <= 1'b0;
            end else if (!core_ready) begin
                if (m_cnt <= 1) core_ready <= 1'b1;
                else m_cnt <= m_cnt - 1;
            end
            if (core_initalize || core_compress || core_finalize) m_pend <= 1'b1;
        end
    end

    // Monitor of the core-side interface, sampled mid-cycle.
    logic [63:0] q_mi[$];
    int n_init, n_comp, n_fin, n_done, comp_at_fin, viol_ready, viol_pulse, mw;
    bit p_init, p_comp, p_fin, p_done;

    always @(negedge clk) begin
        if (!reset_n) begin
            mw = 0; p_init = 0; p_comp = 0; p_fin = 0; p_done = 0;
        end else begin
            if (in_ready && (core_initalize || core_compress || core_finalize || mw != 0)) viol_ready++;
            if ((in_ready || core_initalize || core_compress || core_finalize) && !busy) viol_ready++;
            if ((core_initalize && p_init) || (core_compress && p_comp) ||
                (core_finalize && p_fin) || (done && p_done)) viol_pulse++;
            if (core_initalize) n_init++;
            if (core_compress) begin n_comp++; q_mi.push_back(core_mi); end
            if (core_finalize) begin n_fin++; comp_at_fin = n_comp; end
            if (done) n_done++;
            if (core_compress || core_finalize) mw = 1;
            else if (mw == 1) mw = 2;
            else if (mw == 2 && core_ready) mw = 0;
            p_init = core_initalize; p_comp = core_compress;
            p_fin = core_finalize; p_done = done;
        end
    end

    task automatic mon_clear();
        q_mi.delete();
        n_init = 0; n_comp = 0; n_fin = 0; n_done = 0; comp_at_fin = -1;
        viol_ready = 0; viol_pulse = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " cmds"}, {core_initalize, core_compress, core_finalize}, 0);
        chk({tag, " core_mi"}, core_mi, 0);
        chk({tag, " core_long"}, core_long, 0);
    endtask

    // Send one message and check every observable consequence against the model.
    task automatic send_msg(input int len, input bit hold, input bit seq_data,
                            input int exp_ncomp, input int exp_top, input string tag);
        logic [7:0]  bytes[$];
        logic [63:0] q_exp[$];
        logic [63:0] word, last_mi;
        int idx, cyc;
        bit acc, v;
        for (int i = 0; i < len; i++) bytes.push_back(seq_data ? 8'(i) : 8'($urandom));
        for (int w = 0; w < len / 8; w++) begin
            word = 0;
            for (int k = 0; k < 8; k++) word |= 64'(bytes[8*w+k]) << (8*k);
            q_exp.push_back(word);
        end
        word = 0;
        for (int k = 0; k < len % 8; k++) word |= 64'(bytes[8*(len/8)+k]) << (8*k);
        word |= 64'(len % 256) << 56;
        q_exp.push_back(word);

        mon_clear();
        @(negedge clk);
        start = 1'b1; msg_empty = (len == 0);
        @(posedge clk); #1;
        start = 1'b0; msg_empty = 1'b0;
        @(negedge clk);
        chk({tag, " init pulse"}, {core_initalize, busy, in_ready}, 3'b110);
        @(negedge clk);
        chk({tag, " accept at N+2"}, in_ready, (len > 0));
        idx = 0; cyc = 0;
        while (idx < len && cyc < 5000) begin
            v = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = v ? bytes[idx] : 8'($urandom);
            in_last  = v ? (idx == len - 1) : 1'($urandom_range(0, 1));
            acc = v && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk({tag, " bytes accepted"}, idx, len);
        cyc = 0;
        while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
        chk({tag, " done seen"}, done, 1);
        repeat (4) @(negedge clk);
        chk({tag, " ncomp table"}, n_comp, exp_ncomp);
        chk({tag, " ncomp model"}, n_comp, q_exp.size());
        for (int i = 0; i < q_exp.size() && i < q_mi.size(); i++)
            chk($sformatf("%s word%0d", tag, i), q_mi[i], q_exp[i]);
        last_mi = (q_mi.size() > 0) ? q_mi[q_mi.size()-1] : 64'hx;
        chk({tag, " final top byte"}, last_mi[63:56], exp_top);
        chk({tag, " n_init"}, n_init, 1);
        chk({tag, " n_fin"}, n_fin, 1);
        chk({tag, " fin after last comp"}, comp_at_fin, exp_ncomp);
        chk({tag, " n_done"}, n_done, 1);
        chk({tag, " in_ready rule"}, viol_ready, 0);
        chk({tag, " one-cycle pulses"}, viol_pulse, 0);
        chk({tag, " idle after done"}, {busy, in_ready, core_long}, 0);
    endtask

    typedef struct {
        int len;
        bit hold;
        bit seq;
        int ncomp;
        int top;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc, len;
        bit hold;

        vecs[0] = '{15,  1'b0, 1'b1, 2,  8'h0f};
        vecs[1] = '{0,   1'b0, 1'b1, 1,  8'h00};
        vecs[2] = '{8,   1'b0, 1'b1, 2,  8'h08};
        vecs[3] = '{300, 1'b0, 1'b1, 38, 8'h2c};
        vecs[4] = '{7,   1'b1, 1'b0, 1,  8'h07};
        vecs[5] = '{16,  1'b1, 1'b0, 3,  8'h10};
        vecs[6] = '{257, 1'b1, 1'b0, 33, 8'h01};
        vecs[7] = '{9,   1'b0, 1'b0, 2,  8'h09};

        reset_n = 1'b0; start = 0; msg_empty = 0; in_valid = 0; in_last = 0; in_data = 0;
        mon_clear();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++)
            send_msg(vecs[i].len, vecs[i].hold, vecs[i].seq, vecs[i].ncomp, vecs[i].top,
                     $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            len  = $urandom_range(0, 40);
            hold = 1'($urandom_range(0, 1));
            send_msg(len, hold, 1'b0, len / 8 + 1, len % 256, $sformatf("rnd%0d", i));
        end

        // Reset while the feeder waits on the core after its first compress.
        mon_clear();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!core_compress && cyc < 200) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("rst first compress seen", core_compress, 1);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid-reset");
        repeat (2) @(negedge clk);
        chk_all_zero("mid-reset held");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("post-reset idle");
        send_msg(13, 1'b0, 1'b1, 2, 8'h0d, "after-reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
